hazard_seq: RTL and testbench

HAZARD_SEQ -- requirements
Module: hazard_seq

---
 rtl/hazard_seq.sv | 193 +++++++++++++++++++
 tb/tb_hazard_seq.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/hazard_seq.sv
// -----------------------------------------------------------------------------
// hazard_seq
//
// Pipeline hazard sequencer for a five-stage pipeline. It decides every cycle
// which pipeline registers load, which stages get their control bits zeroed,
// and it freezes the pipeline while the data memory is not ready. A memory
// that stays busy for 256 consecutive cycles is declared hung. The sticky
// TIMEOUT state can only be left through reset.
//
// Optional feature: define HAZARD_SEQ_PERF_EN to add two saturating 16-bit
// performance counters (stall_cycles_o, flush_events_o). Without the macro
// those ports and their logic do not exist.
//
// Ports
//   clk                  clock, all state changes on the rising edge
//   rst_n                asynchronous active-low reset
//   id_rs_i, id_rt_i     source register fields of the instruction in ID
//   ex_memread_i         memRead control bit of the instruction in EX
//   ex_rt_i              destination (rt) of the instruction in EX
//   id_jump_i            J opcode decoded in ID
//   mem_branch_taken_i   taken beq/bne resolved in MEM
//   mem_busy_i           data memory not ready this cycle
//   pc_write_o .. memwb_write_o   pipeline register load enables
//   ifid_flush_o, idex_flush_o, exmem_flush_o  zero that stage's control bits
//   mem_timeout_o        sticky memory-hang flag
//   stall_cycles_o       (HAZARD_SEQ_PERF_EN) cycles with pc_write_o low
//   flush_events_o       (HAZARD_SEQ_PERF_EN) cycles with any flush high
// -----------------------------------------------------------------------------
module hazard_seq (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [4:0] id_rs_i,
    input  logic [4:0] id_rt_i,
    input  logic       ex_memread_i,
    input  logic [4:0] ex_rt_i,
    input  logic       id_jump_i,
    input  logic       mem_branch_taken_i,
    input  logic       mem_busy_i,
    output logic       pc_write_o,
    output logic       ifid_write_o,
    output logic       idex_write_o,
    output logic       exmem_write_o,
    output logic       memwb_write_o,
    output logic       ifid_flush_o,
    output logic       idex_flush_o,
    output logic       exmem_flush_o,
    output logic       mem_timeout_o
`ifdef HAZARD_SEQ_PERF_EN
    ,
    output logic [15:0] stall_cycles_o,
    output logic [15:0] flush_events_o
`endif
);

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        FREEZE  = 2'd1,
        TIMEOUT = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] wait_cnt_q, wait_cnt_d;
    logic       load_use;

    // A load in EX whose destination is read by the instruction in ID.
    // Register 0 is hard-wired to zero, so it never creates a dependency.
    assign load_use = ex_memread_i && (ex_rt_i != 5'd0) &&
                      ((ex_rt_i == id_rs_i) || (ex_rt_i == id_rt_i));

    // Next-state logic
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        case (state_q)
            RUN: begin
                if (mem_busy_i) begin
                    state_d    = FREEZE;
                    wait_cnt_d = 8'd1;
                end
            end
            FREEZE: begin
                if (!mem_busy_i) begin
                    state_d    = RUN;
                    wait_cnt_d = 8'd0;
                end else if (wait_cnt_q == 8'd255) begin
                    // 256th consecutive busy cycle: memory is considered hung
                    state_d = TIMEOUT;
                end else begin
                    wait_cnt_d = wait_cnt_q + 8'd1;
                end
            end
            TIMEOUT: begin
                state_d = TIMEOUT;
            end
            default: begin
                state_d    = RUN;
                wait_cnt_d = 8'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= RUN;
            wait_cnt_q <= 8'd0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    // Output decode. Outputs depend combinationally on rst_n so that the
    // pipeline is held and all control bits are cleared while reset is low.
    always_comb begin
        pc_write_o    = 1'b0;
        ifid_write_o  = 1'b0;
        idex_write_o  = 1'b0;
        exmem_write_o = 1'b0;
        memwb_write_o = 1'b0;
        ifid_flush_o  = 1'b0;
        idex_flush_o  = 1'b0;
        exmem_flush_o = 1'b0;
        mem_timeout_o = 1'b0;
        if (!rst_n) begin
            ifid_flush_o  = 1'b1;
            idex_flush_o  = 1'b1;
            exmem_flush_o = 1'b1;
        end else begin
            case (state_q)
                RUN, FREEZE: begin
                    // A busy memory freezes everything and masks every hazard;
                    // the first ready cycle out of FREEZE behaves like RUN so a
                    // hazard held across the freeze is resolved right then.
                    if (!mem_busy_i) begin
                        pc_write_o    = 1'b1;
                        ifid_write_o  = 1'b1;
                        idex_write_o  = 1'b1;
                        exmem_write_o = 1'b1;
                        memwb_write_o = 1'b1;
                        if (mem_branch_taken_i) begin
                            // Taken branch squashes the three younger stages
                            ifid_flush_o  = 1'b1;
                            idex_flush_o  = 1'b1;
                            exmem_flush_o = 1'b1;
                        end else if (load_use) begin
                            // Hold PC and IF/ID, inject a bubble into ID/EX
                            pc_write_o   = 1'b0;
                            ifid_write_o = 1'b0;
                            idex_flush_o = 1'b1;
                        end else if (id_jump_i) begin
                            ifid_flush_o = 1'b1;
                        end
                    end
                end
                TIMEOUT: begin
                    mem_timeout_o = 1'b1;
                end
                default: begin
                    mem_timeout_o = 1'b0;
                end
            endcase
        end
    end

`ifdef HAZARD_SEQ_PERF_EN
    logic [15:0] stall_cycles_q, flush_events_q;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        if (v == 16'hFFFF) begin
            return v;
        end
        return v + 16'd1;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cycles_q <= 16'd0;
            flush_events_q <= 16'd0;
        end else begin
            if (!pc_write_o) begin
                stall_cycles_q <= sat_inc(stall_cycles_q);
            end
            if (ifid_flush_o || idex_flush_o || exmem_flush_o) begin
                flush_events_q <= sat_inc(flush_events_q);
            end
        end
    end

    assign stall_cycles_o = stall_cycles_q;
    assign flush_events_o = flush_events_q;
`endif

endmodule

// File: tb/tb_hazard_seq.sv
module tb_hazard_seq;

    logic       clk;
    logic       rst_n;
    logic [4:0] id_rs, id_rt, ex_rt;
    logic       ex_memread, id_jump, mem_branch_taken, mem_busy;
    logic       pc_write, ifid_write, idex_write, exmem_write, memwb_write;
    logic       ifid_flush, idex_flush, exmem_flush, mem_timeout;
`ifdef HAZARD_SEQ_PERF_EN
    logic [15:0] stall_cycles, flush_events;
`endif

    hazard_seq dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .id_rs_i            (id_rs),
        .id_rt_i            (id_rt),
        .ex_memread_i       (ex_memread),
        .ex_rt_i            (ex_rt),
        .id_jump_i          (id_jump),
        .mem_branch_taken_i (mem_branch_taken),
        .mem_busy_i         (mem_busy),
        .pc_write_o         (pc_write),
        .ifid_write_o       (ifid_write),
        .idex_write_o       (idex_write),
        .exmem_write_o      (exmem_write),
        .memwb_write_o      (memwb_write),
        .ifid_flush_o       (ifid_flush),
        .idex_flush_o       (idex_flush),
        .exmem_flush_o      (exmem_flush),
        .mem_timeout_o      (mem_timeout)
`ifdef HAZARD_SEQ_PERF_EN
        ,
        .stall_cycles_o     (stall_cycles),
        .flush_events_o     (flush_events)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Output vector: {pc, ifid, idex, exmem, memwb write, ifid/idex/exmem flush, timeout}
    localparam logic [8:0] O_RUN   = 9'b11111_000_0;
    localparam logic [8:0] O_LU    = 9'b00111_010_0;
    localparam logic [8:0] O_BR    = 9'b11111_111_0;
    localparam logic [8:0] O_JMP   = 9'b11111_100_0;
    localparam logic [8:0] O_FRZ   = 9'b00000_000_0;
    localparam logic [8:0] O_TMO   = 9'b00000_000_1;
    localparam logic [8:0] O_RST   = 9'b00000_111_0;

    logic [8:0] out_vec;
    assign out_vec = {pc_write, ifid_write, idex_write, exmem_write, memwb_write,
                      ifid_flush, idex_flush, exmem_flush, mem_timeout};

    typedef struct {
        string      nm;
        logic [4:0] rs, rt, exrt;
        logic       mr, jp, br, bz;
        logic [8:0] exp;
    } vec_t;

    typedef struct {
        string      nm;
        logic [8:0] exp;
    } sb_t;

    sb_t sb[$];
    int  checks = 0;
    int  errors = 0;

    // Monitor: pops the expectation pushed when the stimulus was driven
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            sb_t e;
            e = sb.pop_front();
            checks++;
            if (out_vec !== e.exp) begin
                errors++;
                $display("FAIL %s: got %b expected %b", e.nm, out_vec, e.exp);
            end
        end
    end

    task automatic step(input logic rv, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [4:0] exrt, input logic mr, input logic jp,
                        input logic br, input logic bz, input logic [8:0] exp,
                        input string nm);
        sb_t e;
        @(posedge clk);
        #1;
        rst_n = rv; id_rs = rs; id_rt = rt; ex_rt = exrt;
        ex_memread = mr; id_jump = jp; mem_branch_taken = br; mem_busy = bz;
        e.nm = nm; e.exp = exp;
        sb.push_back(e);
        @(negedge clk);
        #1;
    endtask

    task automatic idle(input logic [8:0] exp, input string nm);
        step(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, exp, nm);
    endtask

    task automatic chk16(input string nm, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    vec_t tbl[10];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{"idle",          5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, O_RUN};
        tbl[1] = '{"lu_rs",         5'd8, 5'd1, 5'd8, 1'b1, 1'b0, 1'b0, 1'b0, O_LU};
        tbl[2] = '{"lu_rt",         5'd2, 5'd5, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, O_LU};
        tbl[3] = '{"r0_no_stall",   5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, O_RUN};
        tbl[4] = '{"no_memread",    5'd8, 5'd8, 5'd8, 1'b0, 1'b0, 1'b0, 1'b0, O_RUN};
        tbl[5] = '{"br_over_lu",    5'd8, 5'd0, 5'd8, 1'b1, 1'b0, 1'b1, 1'b0, O_BR};
        tbl[6] = '{"jump",          5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, O_JMP};
        tbl[7] = '{"lu_over_jump",  5'd9, 5'd0, 5'd9, 1'b1, 1'b1, 1'b0, 1'b0, O_LU};
        tbl[8] = '{"br_over_jump",  5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, O_BR};
        tbl[9] = '{"no_match",      5'd4, 5'd5, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, O_RUN};

        rst_n = 1'b0; id_rs = '0; id_rt = '0; ex_rt = '0;
        ex_memread = 1'b0; id_jump = 1'b0; mem_branch_taken = 1'b0; mem_busy = 1'b0;

        // Reset state: held pipeline, all flushes high
        step(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, O_RST, "reset_out");
        step(1'b0, 5'd8, 5'd8, 5'd8, 1'b1, 1'b1, 1'b1, 1'b1, O_RST, "reset_masks_inputs");
        idle(O_RUN, "after_reset");

        for (int i = 0; i < 10; i++) begin
            step(1'b1, tbl[i].rs, tbl[i].rt, tbl[i].exrt, tbl[i].mr, tbl[i].jp,
                 tbl[i].br, tbl[i].bz, tbl[i].exp, tbl[i].nm);
        end

        // Load-use bubble lasts exactly one cycle once the load moves on
        step(1'b1, 5'd8, 5'd0, 5'd8, 1'b1, 1'b0, 1'b0, 1'b0, O_LU, "lu_bubble");
        idle(O_RUN, "lu_next_cycle");

        // Busy for 5 cycles with load-use held, then resolved on release
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 5'd8, 5'd0, 5'd8, 1'b1, 1'b0, 1'b0, 1'b1, O_FRZ, "freeze_lu");
        end
        step(1'b1, 5'd8, 5'd0, 5'd8, 1'b1, 1'b0, 1'b0, 1'b0, O_LU, "freeze_exit_lu");
        idle(O_RUN, "freeze_back_run");

        // Branch pending across a freeze is resolved on the ready cycle
        step(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, O_FRZ, "freeze_br");
        step(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, O_FRZ, "freeze_br");
        step(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, O_BR, "freeze_exit_br");
        idle(O_RUN, "post_br");

        // Reset in the middle of FREEZE: no delayed flush afterwards
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, O_FRZ, "freeze_pre_rst");
        end
        step(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, O_RST, "rst_mid_freeze");
        idle(O_RUN, "after_freeze_rst");

        // 255 busy cycles (one short of a hang) then release: no timeout
        for (int i = 0; i < 255; i++) begin
            step(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, O_FRZ, "busy_255");
        end
        idle(O_RUN, "busy_255_release");

        // 256 busy cycles: timeout from cycle 257, sticky after busy drops
        for (int i = 0; i < 256; i++) begin
            step(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, O_FRZ, "busy_256");
        end
        step(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, O_TMO, "timeout_257");
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 5'd8, 5'd0, 5'd8, 1'b1, 1'b1, 1'b1, 1'b0, O_TMO, "timeout_sticky");
        end
        step(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, O_RST, "timeout_rst");
        idle(O_RUN, "after_timeout_rst");
        step(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, O_JMP, "after_timeout_jump");

`ifdef HAZARD_SEQ_PERF_EN
        // Counters: load-use bubbles also assert idex_flush, so three bubbles
        // plus two branches give five flush cycles and three stall cycles.
        step(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, O_RST, "perf_rst");
        chk16("stall_after_rst", stall_cycles, 16'd0);
        chk16("flush_after_rst", flush_events, 16'd0);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 5'd7, 5'd0, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, O_LU, "perf_lu");
            idle(O_RUN, "perf_idle");
        end
        for (int i = 0; i < 2; i++) begin
            step(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, O_BR, "perf_br");
            idle(O_RUN, "perf_idle");
        end
        chk16("stall_cycles", stall_cycles, 16'd3);
        chk16("flush_events", flush_events, 16'd5);
        step(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, O_RST, "perf_rst2");
        chk16("stall_cleared", stall_cycles, 16'd0);
        chk16("flush_cleared", flush_events, 16'd0);
        idle(O_RUN, "perf_end");
`endif

        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
